// File: rtl/branch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl_if
// Brief    : EX-stage branch request / fetch redirect bundle for
//            branch_redirect_ctrl. The controller uses the slave side.
// Revision : 1.0  initial release
// ============================================================================
interface branch_redirect_ctrl_if #(
    parameter int TGT_W = 16,
    parameter int CNT_W = 16
);
    // Requests and ALU flags from EX
    logic             br_valid;
    logic             jmp_valid;
    logic [1:0]       br_cond;
    logic             ZF;
    logic             SF;
    logic             OF;
    logic             CF;
    logic [TGT_W-1:0] br_target;
    logic             stall;
    // Redirect / flush towards IF and the pipeline registers
    logic             pc_redirect;
    logic [TGT_W-1:0] redirect_pc;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output br_valid, jmp_valid, br_cond, ZF, SF, OF, CF, br_target, stall,
        input  pc_redirect, redirect_pc, flush, busy, br_count, taken_count
    );

    modport slave (
        input  br_valid, jmp_valid, br_cond, ZF, SF, OF, CF, br_target, stall,
        output pc_redirect, redirect_pc, flush, busy, br_count, taken_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl
// Brief    : Resolves the branch/jump in EX, issues a one-cycle PC redirect
//            followed by a two-cycle wrong-path flush, and keeps saturating
//            branch / taken-branch counters.
// Revision : 1.0  initial release
// ============================================================================
module branch_redirect_ctrl #(
    parameter int TGT_W = 16,
    parameter int CNT_W = 16
) (
    input  wire                      clk,
    input  wire                      rst,
    branch_redirect_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDIR  = 2'd1,
        S_FLUSH2 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TGT_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]   tk_cnt_q, tk_cnt_d;

    logic               w_cond;
    logic               w_taken;
    logic               w_accept;
    logic               w_unused_flags;

    // OF/CF are reserved ALU flags; no condition currently uses them
    assign w_unused_flags = bus.OF ^ bus.CF;

    // Branch condition from ALU flags, then acceptance/taken qualification
    always_comb begin
        w_cond = 1'b0;
        unique case (bus.br_cond)
            2'b00:   w_cond = bus.ZF;
            2'b01:   w_cond = ~bus.ZF;
            2'b10:   w_cond = bus.SF;
            default: w_cond = bus.ZF | ~bus.SF;
        endcase
        w_accept = (state_q == S_IDLE) && !bus.stall && (bus.br_valid || bus.jmp_valid);
        w_taken  = bus.jmp_valid | (bus.br_valid & w_cond);
    end

    // Next state, redirect target and saturating counter updates
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        br_cnt_d      = br_cnt_q;
        tk_cnt_d      = tk_cnt_q;
        if (!bus.stall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!(&br_cnt_q)) br_cnt_d = br_cnt_q + 1'b1;
                        if (w_taken) begin
                            if (!(&tk_cnt_q)) tk_cnt_d = tk_cnt_q + 1'b1;
                            redirect_pc_d = bus.br_target;
                            state_d       = S_REDIR;
                        end
                    end
                end
                S_REDIR:  state_d = S_FLUSH2;
                S_FLUSH2: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            tk_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            tk_cnt_q      <= tk_cnt_d;
        end
    end

    // Outputs are decoded purely from the registered state
    assign bus.pc_redirect = (state_q == S_REDIR);
    assign bus.flush       = (state_q == S_REDIR) || (state_q == S_FLUSH2);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.br_count    = br_cnt_q;
    assign bus.taken_count = tk_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_redirect_ctrl
// Brief    : Self-checking bench for branch_redirect_ctrl. A second instance
//            with 4-bit counters shares the stimulus to reach saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_redirect_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.TGT_W(16), .CNT_W(16)) bif ();
    branch_redirect_ctrl_if #(.TGT_W(16), .CNT_W(4))  sif ();

    // The small-counter instance sees exactly the same inputs
    assign sif.br_valid  = bif.br_valid;
    assign sif.jmp_valid = bif.jmp_valid;
    assign sif.br_cond   = bif.br_cond;
    assign sif.ZF        = bif.ZF;
    assign sif.SF        = bif.SF;
    assign sif.OF        = bif.OF;
    assign sif.CF        = bif.CF;
    assign sif.br_target = bif.br_target;
    assign sif.stall     = bif.stall;

    branch_redirect_ctrl #(.TGT_W(16), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bif));
    branch_redirect_ctrl #(.TGT_W(16), .CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(sif));

    int checks = 0;
    int errors = 0;

    // Reference model: number of flush cycles still owed, plus counters
    int          m_left;
    logic [15:0] m_pc;
    int          m_bc, m_tc;

    function automatic bit cond_true(logic [1:0] c, logic zf, logic sf);
        case (c)
            2'b00:   return zf;
            2'b01:   return !zf;
            2'b10:   return sf;
            default: return zf || !sf;
        endcase
    endfunction

    function automatic logic [50:0] exp_vec();
        logic [15:0] bc, tc;
        bc = (m_bc > 65535) ? 16'hFFFF : m_bc[15:0];
        tc = (m_tc > 65535) ? 16'hFFFF : m_tc[15:0];
        return {m_left == 2, m_left > 0, m_left > 0, m_pc, bc, tc};
    endfunction

    function automatic logic [7:0] exp_small();
        logic [3:0] bc, tc;
        bc = (m_bc > 15) ? 4'hF : m_bc[3:0];
        tc = (m_tc > 15) ? 4'hF : m_tc[3:0];
        return {bc, tc};
    endfunction

    function automatic logic [50:0] got_vec();
        return {bif.pc_redirect, bif.flush, bif.busy, bif.redirect_pc, bif.br_count, bif.taken_count};
    endfunction

    task automatic model_clear();
        m_left = 0; m_pc = '0; m_bc = 0; m_tc = 0;
    endtask

    task automatic drive(input logic brv, input logic jmpv, input logic [1:0] c,
                         input logic zf, input logic sf, input logic [15:0] tgt, input logic stl);
        bif.br_valid = brv; bif.jmp_valid = jmpv; bif.br_cond = c;
        bif.ZF = zf; bif.SF = sf; bif.OF = 1'b0; bif.CF = 1'b0;
        bif.br_target = tgt; bif.stall = stl;
    endtask

    // One clock edge; the model consumes the inputs present at that edge
    task automatic tick();
        @(posedge clk);
        if (!bif.stall) begin
            if (m_left == 0) begin
                if (bif.br_valid || bif.jmp_valid) begin
                    m_bc++;
                    if (bif.jmp_valid || (bif.br_valid && cond_true(bif.br_cond, bif.ZF, bif.SF))) begin
                        m_tc++;
                        m_left = 2;
                        m_pc   = bif.br_target;
                    end
                end
            end else begin
                m_left--;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 2'b00, 0, 0, 16'h0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got_vec() !== 51'b0) begin
            errors++; $display("FAIL reset_state got=%h want=0", got_vec());
        end
        @(negedge clk); rst = 1'b0;
        tick();
        checks++;
        if (got_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_idle got=%h want=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_taken_beqz();
        drive(1, 0, 2'b00, 1, 0, 16'h0040, 0);
        tick();
        drive(0, 0, 2'b00, 0, 0, 16'h0, 0);
        checks++;
        if ({bif.pc_redirect, bif.flush, bif.redirect_pc} !== {1'b1, 1'b1, 16'h0040}) begin
            errors++; $display("FAIL beqz_n1 got=%b%b %h want=11 0040", bif.pc_redirect, bif.flush, bif.redirect_pc);
        end
        tick();
        checks++;
        if ({bif.pc_redirect, bif.flush} !== 2'b01) begin
            errors++; $display("FAIL beqz_n2 got=%b%b want=01", bif.pc_redirect, bif.flush);
        end
        tick();
        checks++;
        if ({bif.busy, bif.flush, bif.br_count, bif.taken_count} !== {1'b0, 1'b0, 16'd1, 16'd1}) begin
            errors++; $display("FAIL beqz_n3 got busy=%b cnt=%0d/%0d want busy=0 cnt=1/1", bif.busy, bif.br_count, bif.taken_count);
        end
    endtask

    task automatic test_not_taken();
        drive(1, 0, 2'b01, 1, 0, 16'hAAAA, 0);
        tick();
        checks++;
        if ({bif.pc_redirect, bif.flush} !== 2'b00) begin
            errors++; $display("FAIL bnez_nt got=%b%b want=00", bif.pc_redirect, bif.flush);
        end
        drive(1, 0, 2'b11, 0, 1, 16'h5555, 0);
        tick();
        drive(0, 0, 2'b00, 0, 0, 16'h0, 0);
        checks++;
        if ({bif.pc_redirect, bif.flush, bif.br_count, bif.taken_count, bif.redirect_pc}
            !== {2'b00, 16'd3, 16'd1, 16'h0040}) begin
            errors++; $display("FAIL not_taken got=%b%b cnt=%0d/%0d pc=%h want=00 cnt=3/1 pc=0040",
                               bif.pc_redirect, bif.flush, bif.br_count, bif.taken_count, bif.redirect_pc);
        end
    endtask

    task automatic test_jump_stall();
        drive(0, 1, 2'b00, 0, 0, 16'h1234, 0);
        tick();
        drive(0, 0, 2'b00, 0, 0, 16'h0, 1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bif.stall = 1'b0;
            checks++;
            if ({bif.pc_redirect, bif.flush, bif.redirect_pc} !== {2'b11, 16'h1234}) begin
                errors++; $display("FAIL jmp_stall_redir cycle=%0d got=%b%b %h want=11 1234",
                                   i, bif.pc_redirect, bif.flush, bif.redirect_pc);
            end
            tick();
        end
        checks++;
        if ({bif.pc_redirect, bif.flush, bif.redirect_pc} !== {2'b01, 16'h1234}) begin
            errors++; $display("FAIL jmp_flush2 got=%b%b %h want=01 1234", bif.pc_redirect, bif.flush, bif.redirect_pc);
        end
        tick();
        // Stall in IDLE blocks acceptance; the request counts once when it goes
        drive(1, 0, 2'b10, 0, 1, 16'h0BEE, 1);
        tick(); tick();
        checks++;
        if (got_vec() !== exp_vec() || bif.busy !== 1'b0) begin
            errors++; $display("FAIL idle_stall got=%h want=%h", got_vec(), exp_vec());
        end
        bif.stall = 1'b0;
        tick();
        drive(0, 0, 2'b00, 0, 0, 16'h0, 0);
        checks++;
        if ({bif.pc_redirect, bif.redirect_pc, bif.br_count, bif.taken_count} !== {1'b1, 16'h0BEE, 16'd5, 16'd3}) begin
            errors++; $display("FAIL idle_stall_release got=%b %h %0d/%0d want=1 0bee 5/3",
                               bif.pc_redirect, bif.redirect_pc, bif.br_count, bif.taken_count);
        end
        tick(); tick();
    endtask

    task automatic test_ignored();
        logic [15:0] bc0;
        bc0 = bif.br_count;
        drive(1, 0, 2'b00, 1, 0, 16'h0100, 0);
        tick();
        bif.br_target = 16'h0200;
        tick(); tick();
        checks++;
        if (bif.br_count !== bc0 + 16'd1 || bif.redirect_pc !== 16'h0100) begin
            errors++; $display("FAIL ignored got cnt=%0d pc=%h want cnt=%0d pc=0100", bif.br_count, bif.redirect_pc, bc0 + 16'd1);
        end
        tick();
        drive(0, 0, 2'b00, 0, 0, 16'h0, 0);
        checks++;
        if ({bif.pc_redirect, bif.redirect_pc} !== {1'b1, 16'h0200} || bif.br_count !== bc0 + 16'd2) begin
            errors++; $display("FAIL accept_n3 got=%b %h cnt=%0d want=1 0200 cnt=%0d",
                               bif.pc_redirect, bif.redirect_pc, bif.br_count, bc0 + 16'd2);
        end
        tick(); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) < 5, $urandom_range(0, 9) < 2, 2'($urandom),
                  1'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, 9) < 2);
            bif.OF = 1'($urandom); bif.CF = 1'($urandom);
            tick();
            checks++;
            if (got_vec() !== exp_vec() || {sif.br_count, sif.taken_count} !== exp_small()) begin
                errors++; $display("FAIL random cycle=%0d got=%h/%h want=%h/%h",
                                   i, got_vec(), {sif.br_count, sif.taken_count}, exp_vec(), exp_small());
            end
        end
        drive(0, 0, 2'b00, 0, 0, 16'h0, 0);
        repeat (3) tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 2'b00, 1, 0, 16'(i), 0);
            tick();
            drive(0, 0, 2'b00, 0, 0, 16'h0, 0);
            tick(); tick();
        end
        checks++;
        if ({sif.br_count, sif.taken_count} !== 8'hFF || sif.redirect_pc !== 16'd19) begin
            errors++; $display("FAIL saturation got=%h pc=%h want=ff pc=0013", {sif.br_count, sif.taken_count}, sif.redirect_pc);
        end
        checks++;
        if (got_vec() !== exp_vec()) begin
            errors++; $display("FAIL sat_main got=%h want=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1, 2'b00, 0, 0, 16'hBEEF, 0);
        tick();
        drive(0, 0, 2'b00, 0, 0, 16'h0, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (got_vec() !== 51'b0 || {sif.br_count, sif.taken_count} !== 8'h00) begin
            errors++; $display("FAIL async_reset got=%h want=0", got_vec());
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (got_vec() !== 51'b0) begin
                errors++; $display("FAIL post_reset cycle=%0d got=%h want=0", i, got_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_taken_beqz();
        test_not_taken();
        test_jump_stall();
        test_ignored();
        test_random();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
